// File: rtl/fifo_packetizer_pkg.sv
// Shared definitions for the FIFO packetizer: state encodings and default header word.
package fifo_packetizer_pkg;

  // Frame sequencer states; encodings are fixed so they can be probed/compared externally.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StHeader   = 3'd1,
    StPayload  = 3'd2,
    StLength   = 3'd3,
    StChecksum = 3'd4
  } pkt_state_e;

  // Default constant first word of every packet.
  localparam logic [7:0] DefaultHeaderWord = 8'hA5;

endpackage

// File: rtl/packet_checksum.sv
// Modular running-sum accumulator: clear has priority over load, load over add.
module packet_checksum #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  add_enable,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic [DATA_WIDTH-1:0] add_value,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // Next sum; carries out of DATA_WIDTH are dropped.
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (load) begin
      sum_d = load_value;
    end else if (add_enable) begin
      sum_d = sum_q + add_value;
    end
  end

  // Sum register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/fifo_packetizer.sv
// Drains a show-ahead FIFO into framed packets: header, payload, length, checksum.
module fifo_packetizer
  import fifo_packetizer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           MAX_PAYLOAD    = 16,
  parameter int unsigned           TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] HEADER_WORD    = DATA_WIDTH'(DefaultHeaderWord)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           packets_sent
);

  localparam int unsigned CountWidth = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);

  pkt_state_e            state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [15:0]           packets_q, packets_d;

  logic                  sum_clear, sum_load, sum_add;
  logic [DATA_WIDTH-1:0] sum_addend;
  logic [DATA_WIDTH-1:0] sum;

  packet_checksum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_checksum (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (sum_clear),
    .load       (sum_load),
    .add_enable (sum_add),
    .load_value (HEADER_WORD),
    .add_value  (sum_addend),
    .sum        (sum)
  );

  // Next-state, counters and stream outputs; PAYLOAD passes the FIFO head straight through.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    timer_d          = timer_q;
    packets_d        = packets_q;
    out_valid        = 1'b0;
    out_last         = 1'b0;
    out_data         = '0;
    fifo_read_enable = 1'b0;
    sum_clear        = 1'b0;
    sum_load         = 1'b0;
    sum_add          = 1'b0;
    sum_addend       = '0;

    unique case (state_q)
      StIdle: begin
        count_d   = '0;
        timer_d   = '0;
        sum_clear = 1'b1;
        if (!fifo_empty) begin
          state_d = StHeader;
        end
      end

      StHeader: begin
        out_valid = 1'b1;
        out_data  = HEADER_WORD;
        if (out_ready) begin
          sum_load = 1'b1;
          state_d  = StPayload;
        end
      end

      StPayload: begin
        out_valid = ~fifo_empty;
        out_data  = fifo_data_out;
        if (!fifo_empty) begin
          // Any cycle with data present breaks the run of empty cycles.
          timer_d = '0;
          if (out_ready) begin
            fifo_read_enable = 1'b1;
            count_d          = count_q + CountWidth'(1);
            sum_add          = 1'b1;
            sum_addend       = fifo_data_out;
            if (count_q == CountWidth'(MAX_PAYLOAD - 1)) begin
              state_d = StLength;
            end
          end
        end else begin
          // Timeout exit only happens while out_valid is low, so no word is withdrawn.
          timer_d = timer_q + TimerWidth'(1);
          if (timer_q == TimerWidth'(TIMEOUT_CYCLES - 1)) begin
            state_d = StLength;
          end
        end
      end

      StLength: begin
        out_valid = 1'b1;
        out_data  = DATA_WIDTH'(count_q);
        if (out_ready) begin
          sum_add    = 1'b1;
          sum_addend = DATA_WIDTH'(count_q);
          state_d    = StChecksum;
        end
      end

      StChecksum: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = sum;
        if (out_ready) begin
          packets_d = packets_q + 16'd1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, word count, empty timer and packet counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      timer_q   <= '0;
      packets_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      packets_q <= packets_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign packets_sent = packets_q;

endmodule

// File: tb/tb_fifo_packetizer.sv
// Self-checking bench: show-ahead FIFO model, frame scoreboard, stream protocol checks.
module tb_fifo_packetizer;

  localparam int unsigned DW      = 8;
  localparam int unsigned MaxPay  = 4;
  localparam int unsigned Timeout = 8;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic [15:0]   packets_sent;

  fifo_packetizer #(
    .DATA_WIDTH     (DW),
    .MAX_PAYLOAD    (MaxPay),
    .TIMEOUT_CYCLES (Timeout),
    .HEADER_WORD    (8'hA5)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .fifo_data_out    (fifo_data_out),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .out_ready        (out_ready),
    .busy             (busy),
    .packets_sent     (packets_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // kind: 0 header, 1 payload, 2 length, 3 checksum
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] kind;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] words[$];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         n_payload = 0;
  int         last_cyc[4];
  int         push_cyc;
  logic       pop_now    = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic update_fifo();
    fifo_empty    = (fifo_q.size() == 0);
    fifo_data_out = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    update_fifo();
  endtask

  // Reference framing of the words currently in 'words'.
  task automatic expect_frame();
    logic [7:0] s;
    logic [7:0] len;
    s   = 8'hA5;
    len = 8'(words.size());
    exp_q.push_back('{data: 8'hA5, last: 1'b0, kind: 2'd0});
    foreach (words[i]) begin
      s = s + words[i];
      exp_q.push_back('{data: words[i], last: 1'b0, kind: 2'd1});
    end
    s = s + len;
    exp_q.push_back('{data: len, last: 1'b0, kind: 2'd2});
    exp_q.push_back('{data: s, last: 1'b1, kind: 2'd3});
    words.delete();
  endtask

  task automatic monitor();
    exp_t e;
    cyc++;
    if (prev_stall) begin
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_data", out_data, prev_data);
    end
    if (fifo_read_enable) check_eq("pop_nonempty", fifo_empty, 1'b0);
    if (out_valid && !out_ready) check_eq("stall_no_pop", fifo_read_enable, 1'b0);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("stray_word", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("data", out_data, e.data);
        check_eq("last", out_last, e.last);
        check_eq("pop_on_payload", fifo_read_enable, e.kind == 2'd1);
        last_cyc[e.kind] = cyc;
        if (e.kind == 2'd1) n_payload++;
      end
    end
    pop_now = fifo_read_enable;
  endtask

  // One clock: sample at the falling edge, update the FIFO model just after the rising edge.
  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    update_fifo();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || busy) check_eq("drain_timeout", exp_q.size() + int'(busy), 0);
  endtask

  task automatic wait_payload(input int budget);
    int target;
    int n;
    target = n_payload + 1;
    n = 0;
    while (n_payload < target && n < budget) begin
      tick();
      n++;
    end
    if (n_payload < target) check_eq("payload_timeout", n_payload, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    foreach (last_cyc[i]) last_cyc[i] = 0;
    reset_n   = 1'b0;
    out_ready = 1'b0;
    update_fifo();
    #1;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_last", out_last, 1'b0);
    check_eq("rst_data", out_data, 8'h00);
    check_eq("rst_ren", fifo_read_enable, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pkts", packets_sent, 16'd0);
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;

    // Full packet, plus header latency and packet duration.
    push_cyc = cyc;
    for (int i = 1; i <= 4; i++) begin
      push_word(8'(i));
      words.push_back(8'(i));
    end
    expect_frame();
    drain(40);
    check_eq("hdr_latency", last_cyc[0] - push_cyc, 2);
    check_eq("pkt_duration", last_cyc[3] - last_cyc[0], MaxPay + 2);
    check_eq("pkts_1", packets_sent, 16'd1);

    // Six words: forced close at MAX_PAYLOAD, then timeout close of the remainder.
    for (int i = 0; i < 6; i++) push_word(8'(8'h10 + i));
    for (int i = 0; i < 4; i++) words.push_back(8'(8'h10 + i));
    expect_frame();
    words.push_back(8'h14);
    words.push_back(8'h15);
    expect_frame();
    drain(80);
    check_eq("pkts_3", packets_sent, 16'd3);

    // Single word, closed by timeout after 8 empty cycles.
    push_word(8'h07);
    words.push_back(8'h07);
    expect_frame();
    drain(60);
    check_eq("timeout_gap", last_cyc[2] - last_cyc[1], Timeout + 1);
    check_eq("pkts_4", packets_sent, 16'd4);

    // Back-pressure mid-payload with data waiting: hold, no pops, no timeout.
    for (int i = 0; i < 4; i++) begin
      push_word(8'(8'h20 + i));
      words.push_back(8'(8'h20 + i));
    end
    expect_frame();
    wait_payload(20);
    out_ready = 1'b0;
    for (int i = 0; i < Timeout + 2; i++) tick();
    check_eq("stall_fifo_level", fifo_q.size(), 3);
    check_eq("stall_busy", busy, 1'b1);
    check_eq("stall_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    drain(40);
    check_eq("pkts_5", packets_sent, 16'd5);

    // Reset mid-payload abandons the packet.
    for (int i = 0; i < 4; i++) begin
      push_word(8'(8'h30 + i));
      words.push_back(8'(8'h30 + i));
    end
    expect_frame();
    wait_payload(20);
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_data", out_data, 8'h00);
    check_eq("mid_rst_last", out_last, 1'b0);
    check_eq("mid_rst_ren", fifo_read_enable, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_pkts", packets_sent, 16'd0);
    exp_q.delete();
    fifo_q.delete();
    update_fifo();
    prev_stall = 1'b0;
    pop_now    = 1'b0;
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    push_word(8'h40);
    words.push_back(8'h40);
    expect_frame();
    drain(60);
    check_eq("pkts_after_rst", packets_sent, 16'd1);

    // Checksum wrap-around.
    for (int i = 0; i < 4; i++) begin
      push_word(8'hFF);
      words.push_back(8'hFF);
    end
    expect_frame();
    drain(40);
    check_eq("pkts_wrap", packets_sent, 16'd2);
    check_eq("end_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
